next_pc_unit: RTL and testbench
===============================

# next_pc_unit

Computes the next program-counter value each cycle and feeds the PC register's `d` input directly. Selects among sequential increment, jump/branch target, subroutine return address and hold (stall). Contains a LIFO return-address stack so the CPU supports nested `jsr`/`ret`. Sits between the control unit (which raises the control strobes) and the PC register (which loads every cycle).

## Interface
Parameters:
- `ADDR_W`, 12: program address width; matches PC register width.
- `DEPTH`, 8: return-stack entries; must be ≥2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `pc`  in  ADDR_W  current PC (PC register `q`).
- `stall`  in  1  hold PC; overrides all other strobes.
- `jmp`  in  1  unconditional jump to `target`.
- `br_taken`  in  1  conditional branch resolved taken; go to `target`.
- `jsr`  in  1  call: push `pc+1`, go to `target`.
- `ret`  in  1  return: pop, go to the popped address.
- `target`  in  ADDR_W  jump/branch/call destination.
- `next_pc`  out  ADDR_W  value for the PC register `d`.
- `depth`  out  $clog2(DEPTH+1)  valid stack entries.
- `empty`  out  1  `depth==0`.
- `full`  out  1  `depth==DEPTH`.
- `ovf`  out  1  sticky: a `jsr` occurred while `full`.
- `unf`  out  1  sticky: a `ret` occurred while `empty`.

## Operation
- Priority, evaluated combinationally each cycle: `rst` > `stall` > `ret` > `jsr` > `jmp` > `br_taken` > increment.
- `rst`: `next_pc`=0; stack pointer cleared; `ovf`, `unf` cleared; no push or pop.
- `stall`: `next_pc`=`pc`; stack and flags unchanged.
- `ret`, not empty: `next_pc`=top entry; pop (depth−1) at the edge.
- `ret`, empty: `next_pc`=`pc+1`; no pop; `unf` set at the edge.
- `jsr`, not full: `next_pc`=`target`; push `pc+1` at the edge.
- `jsr`, full: `next_pc`=`target`; push dropped (existing entries untouched); `ovf` set at the edge.
- `jmp` or `br_taken`: `next_pc`=`target`.
- Otherwise: `next_pc`=`pc+1`.
- Arithmetic: `pc+1` is modulo 2^ADDR_W, so 0xFFF+1=0x000. The same wrapped value is what `jsr` pushes.
- Stack storage is not reset. Only the pointer and flags are reset. Entry contents are never read when `empty`.
- `ovf` and `unf` stay set until `rst`.

## Timing
- `next_pc` is combinational from the inputs plus registered stack state: zero-cycle latency, so the PC register captures it on the same edge.
- Push, pop, `depth`, `empty`, `full` and the flags all update on the rising edge. `depth`, `empty` and `full` are registered-derived and glitch-free.
- Back-to-back `jsr` then `ret`: the `ret` cycle returns the address pushed on the previous edge.
- Reset values: `depth`=0, `empty`=1, `full`=0, `ovf`=0, `unf`=0. `next_pc`=0 while `rst` is high.
- `rst` asserted mid-sequence discards all stacked addresses on that edge.

## Structure
- Shared package `cpu_pkg`:
  - `ADDR_W` constant.
  - `pc_sel_e` enum {`PC_INC`, `PC_TARGET`, `PC_STACK`, `PC_HOLD`}.
- `next_pc_unit` holds:
  - the priority select logic producing `pc_sel_e`;
  - the output mux;
  - the sticky flag registers.
- Sub-module `return_stack` (parameterised on `ADDR_W`, `DEPTH`) contains:
  - the LIFO array and pointer;
  - `push`/`pop` inputs and `top`, `depth`, `empty`, `full` outputs;
  - push ignored when full, pop ignored when empty.

## Test plan
- Reset, then idle with `pc`=0x010 → `next_pc`=0x011, `depth`=0, `empty`=1. With `pc`=0xFFF → `next_pc`=0x000.
- Call/return with `pc`=0x020:
  - `jsr`, `target`=0x100 → `next_pc`=0x100; `depth`=1 after the edge.
  - Next cycle `pc`=0x100, `ret` → `next_pc`=0x021; `depth`=0 after the edge.
- Nest 8 calls from `pc`=0x001..0x008 → `full`=1. A 9th `jsr` → jumps to `target`, `ovf`=1, `depth` stays 8. 8 `ret`s → 0x009, 0x008, … 0x002 in order.
- `ret` while empty with `pc`=0x050 → `next_pc`=0x051, `unf`=1, `depth`=0. `unf` stays 1 until `rst`.
- `stall`+`jsr` together with `pc`=0x030 → `next_pc`=0x030, no push. `jmp`+`br_taken`, `target`=0x3AA → 0x3AA.
- Push 3 entries, assert `rst` → `depth`=0, flags cleared, `next_pc`=0. A subsequent `ret` → `unf`=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: program address width and next-PC source selection.
package cpu_pkg;

  localparam int ADDR_W = 12;

  typedef enum logic [1:0] {
    PC_INC,
    PC_TARGET,
    PC_STACK,
    PC_HOLD
  } pc_sel_e;

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses for nested calls; push ignored when full, pop ignored when empty.
module return_stack #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8,
  localparam int PW    = $clog2(DEPTH + 1),
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] top,
  output logic [PW-1:0]     depth,
  output logic              empty,
  output logic              full
);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PW-1:0]     sp;
  logic              do_push;
  logic              do_pop;

  assign empty   = (sp == '0);
  assign full    = (sp == PW'(DEPTH));
  assign depth   = sp;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !push;

  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
    end else if (do_push) begin
      sp <= sp + PW'(1);
    end else if (do_pop) begin
      sp <= sp - PW'(1);
    end
  end

  // Storage is deliberately not reset; only the pointer defines validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[IW'(sp)] <= din;
    end
  end

  assign top = mem[IW'(sp - PW'(1))];

endmodule

// File: rtl/next_pc_unit.sv
// Next-PC selection: hold, return, call, jump/branch or increment, with a return-address stack.
module next_pc_unit #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8,
  localparam int DW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              stall,
  input  logic              jmp,
  input  logic              br_taken,
  input  logic              jsr,
  input  logic              ret,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] next_pc,
  output logic [DW-1:0]     depth,
  output logic              empty,
  output logic              full,
  output logic              ovf,
  output logic              unf
);

  import cpu_pkg::*;

  pc_sel_e           sel;
  logic              push;
  logic              pop;
  logic              ovf_set;
  logic              unf_set;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] stack_top;

  assign pc_inc = pc + ADDR_W'(1);

  always_comb begin
    sel     = PC_INC;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (rst) begin
      sel = PC_INC;
    end else if (stall) begin
      sel = PC_HOLD;
    end else if (ret) begin
      if (empty) begin
        unf_set = 1'b1;
      end else begin
        sel = PC_STACK;
        pop = 1'b1;
      end
    end else if (jsr) begin
      sel     = PC_TARGET;
      push    = !full;
      ovf_set = full;
    end else if (jmp || br_taken) begin
      sel = PC_TARGET;
    end
  end

  always_comb begin
    next_pc = pc_inc;
    if (rst) begin
      next_pc = '0;
    end else begin
      case (sel)
        PC_HOLD:   next_pc = pc;
        PC_STACK:  next_pc = stack_top;
        PC_TARGET: next_pc = target;
        default:   next_pc = pc_inc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (ovf_set) ovf <= 1'b1;
      if (unf_set) unf <= 1'b1;
    end
  end

  return_stack #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (pc_inc),
    .top  (stack_top),
    .depth(depth),
    .empty(empty),
    .full (full)
  );

endmodule

// File: tb/tb_next_pc_unit.sv
// Scenario bench for next_pc_unit: expected next_pc values queued on drive, popped on sample.
module tb_next_pc_unit;

  logic        clk = 1'b0;
  logic        rst, stall, jmp, br_taken, jsr, ret;
  logic [11:0] pc, target, next_pc;
  logic [3:0]  depth;
  logic        empty, full, ovf, unf;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [11:0] exp;
    string       name;
  } sb_t;
  sb_t sb[$];
  sb_t e;

  always #5 clk = ~clk;

  next_pc_unit #(.ADDR_W(12), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .pc(pc), .stall(stall), .jmp(jmp),
    .br_taken(br_taken), .jsr(jsr), .ret(ret), .target(target),
    .next_pc(next_pc), .depth(depth), .empty(empty), .full(full),
    .ovf(ovf), .unf(unf)
  );

  // Drive one cycle of inputs at the falling edge and queue the expected next_pc.
  task automatic go(input logic r, input logic [11:0] p, input logic s, input logic js,
                    input logic rt, input logic jm, input logic b, input logic [11:0] t,
                    input logic [11:0] exp, input string name);
    @(negedge clk);
    rst = r; pc = p; stall = s; jsr = js; ret = rt; jmp = jm; br_taken = b; target = t;
    sb.push_back('{exp, name});
    #1;
  endtask

  task automatic test_reset;
    go(1, 12'h123, 0, 1, 0, 0, 0, 12'h456, 12'h000, "reset_next_pc");
    e = sb.pop_front(); checks++;
    if (next_pc !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, next_pc, e.exp); end
    @(posedge clk); #1;
    checks++;
    if ({depth, empty, full, ovf, unf} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_state: depth=%0d empty=%b full=%b ovf=%b unf=%b want 0 1 0 0 0",
                         depth, empty, full, ovf, unf);
    end
  endtask

  task automatic test_increment;
    go(0, 12'h010, 0, 0, 0, 0, 0, 12'h000, 12'h011, "inc_010");
    e = sb.pop_front(); checks++;
    if (next_pc !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, next_pc, e.exp); end
    @(posedge clk); #1;
    checks++;
    if (depth !== 4'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL idle_depth: depth=%0d empty=%b want 0 1", depth, empty);
    end
    go(0, 12'hFFF, 0, 0, 0, 0, 0, 12'h000, 12'h000, "inc_wrap");
    e = sb.pop_front(); checks++;
    if (next_pc !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, next_pc, e.exp); end
  endtask

  task automatic test_call_return;
    go(0, 12'h020, 0, 1, 0, 0, 0, 12'h100, 12'h100, "jsr_target");
    e = sb.pop_front(); checks++;
    if (next_pc !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, next_pc, e.exp); end
    @(posedge clk); #1;
    checks++;
    if (depth !== 4'd1 || empty !== 1'b0) begin
      errors++; $display("FAIL jsr_depth: depth=%0d empty=%b want 1 0", depth, empty);
    end
    go(0, 12'h100, 0, 0, 1, 0, 0, 12'h000, 12'h021, "ret_back_to_back");
    e = sb.pop_front(); checks++;
    if (next_pc !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, next_pc, e.exp); end
    @(posedge clk); #1;
    checks++;
    if (depth !== 4'd0) begin errors++; $display("FAIL ret_depth: depth=%0d want 0", depth); end
    // Call from the top of the address space pushes the wrapped return address.
    go(0, 12'hFFF, 0, 1, 0, 0, 0, 12'h200, 12'h200, "jsr_at_fff");
    e = sb.pop_front(); checks++;
    if (next_pc !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, next_pc, e.exp); end
    go(0, 12'h200, 0, 0, 1, 0, 0, 12'h000, 12'h000, "ret_wrapped");
    e = sb.pop_front(); checks++;
    if (next_pc !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, next_pc, e.exp); end
  endtask

  task automatic test_nested;
    for (int i = 1; i <= 8; i++) begin
      go(0, 12'(i), 0, 1, 0, 0, 0, 12'h200 + 12'(i), 12'h200 + 12'(i), "nest_jsr");
      e = sb.pop_front(); checks++;
      if (next_pc !== e.exp) begin errors++; $display("FAIL %s[%0d]: got %h want %h", e.name, i, next_pc, e.exp); end
      @(posedge clk); #1;
      checks++;
      if (depth !== 4'(i)) begin errors++; $display("FAIL nest_depth[%0d]: depth=%0d want %0d", i, depth, i); end
    end
    checks++;
    if (full !== 1'b1 || ovf !== 1'b0) begin
      errors++; $display("FAIL nest_full: full=%b ovf=%b want 1 0", full, ovf);
    end
    go(0, 12'h009, 0, 1, 0, 0, 0, 12'h300, 12'h300, "jsr_when_full");
    e = sb.pop_front(); checks++;
    if (next_pc !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, next_pc, e.exp); end
    @(posedge clk); #1;
    checks++;
    if (ovf !== 1'b1 || depth !== 4'd8 || full !== 1'b1) begin
      errors++; $display("FAIL overflow: ovf=%b depth=%0d full=%b want 1 8 1", ovf, depth, full);
    end
    for (int k = 0; k < 8; k++) begin
      go(0, 12'h0F0, 0, 0, 1, 0, 0, 12'h000, 12'h009 - 12'(k), "nest_ret");
      e = sb.pop_front(); checks++;
      if (next_pc !== e.exp) begin errors++; $display("FAIL %s[%0d]: got %h want %h", e.name, k, next_pc, e.exp); end
      @(posedge clk); #1;
      checks++;
      if (depth !== 4'(7 - k)) begin errors++; $display("FAIL unnest_depth[%0d]: depth=%0d want %0d", k, depth, 7 - k); end
    end
    checks++;
    if (empty !== 1'b1 || ovf !== 1'b1) begin
      errors++; $display("FAIL after_unnest: empty=%b ovf=%b want 1 1", empty, ovf);
    end
  endtask

  task automatic test_ret_empty;
    go(0, 12'h050, 0, 0, 1, 0, 0, 12'h000, 12'h051, "ret_empty");
    e = sb.pop_front(); checks++;
    if (next_pc !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, next_pc, e.exp); end
    @(posedge clk); #1;
    checks++;
    if (unf !== 1'b1 || depth !== 4'd0) begin
      errors++; $display("FAIL underflow: unf=%b depth=%0d want 1 0", unf, depth);
    end
    for (int i = 0; i < 3; i++) begin
      go(0, 12'h060 + 12'(i), 0, 0, 0, 0, 0, 12'h000, 12'h061 + 12'(i), "idle_after_unf");
      e = sb.pop_front(); checks++;
      if (next_pc !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, next_pc, e.exp); end
    end
    @(posedge clk); #1;
    checks++;
    if (unf !== 1'b1) begin errors++; $display("FAIL unf_sticky: unf=%b want 1", unf); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) begin
      go(0, 12'h040 + 12'(i), 0, 1, 0, 0, 0, 12'h400, 12'h400, "push3");
      e = sb.pop_front(); checks++;
      if (next_pc !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, next_pc, e.exp); end
    end
    @(posedge clk); #1;
    checks++;
    if (depth !== 4'd3) begin errors++; $display("FAIL push3_depth: depth=%0d want 3", depth); end
    go(1, 12'h400, 0, 0, 1, 0, 0, 12'h000, 12'h000, "rst_mid");
    e = sb.pop_front(); checks++;
    if (next_pc !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, next_pc, e.exp); end
    @(posedge clk); #1;
    checks++;
    if ({depth, empty, ovf, unf} !== {4'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rst_mid_state: depth=%0d empty=%b ovf=%b unf=%b want 0 1 0 0", depth, empty, ovf, unf);
    end
    go(0, 12'h060, 0, 0, 1, 0, 0, 12'h000, 12'h061, "ret_after_rst");
    e = sb.pop_front(); checks++;
    if (next_pc !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, next_pc, e.exp); end
    @(posedge clk); #1;
    checks++;
    if (unf !== 1'b1 || depth !== 4'd0) begin
      errors++; $display("FAIL unf_after_rst: unf=%b depth=%0d want 1 0", unf, depth);
    end
  endtask

  task automatic test_priority;
    go(1, 12'h000, 0, 0, 0, 0, 0, 12'h000, 12'h000, "prio_reset");
    e = sb.pop_front(); checks++;
    if (next_pc !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, next_pc, e.exp); end
    go(0, 12'h030, 1, 1, 0, 0, 0, 12'h100, 12'h030, "stall_jsr");
    e = sb.pop_front(); checks++;
    if (next_pc !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, next_pc, e.exp); end
    @(posedge clk); #1;
    checks++;
    if (depth !== 4'd0) begin errors++; $display("FAIL stall_no_push: depth=%0d want 0", depth); end
    go(0, 12'h031, 0, 0, 0, 1, 1, 12'h3AA, 12'h3AA, "jmp_br");
    e = sb.pop_front(); checks++;
    if (next_pc !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, next_pc, e.exp); end
    go(0, 12'h032, 0, 0, 0, 0, 1, 12'h155, 12'h155, "br_only");
    e = sb.pop_front(); checks++;
    if (next_pc !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, next_pc, e.exp); end
    go(0, 12'h070, 0, 1, 0, 1, 0, 12'h500, 12'h500, "jsr_over_jmp");
    e = sb.pop_front(); checks++;
    if (next_pc !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, next_pc, e.exp); end
    go(0, 12'h500, 0, 1, 1, 0, 0, 12'h600, 12'h071, "ret_over_jsr");
    e = sb.pop_front(); checks++;
    if (next_pc !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, next_pc, e.exp); end
    @(posedge clk); #1;
    checks++;
    if (depth !== 4'd0 || ovf !== 1'b0 || unf !== 1'b0) begin
      errors++; $display("FAIL ret_over_jsr_state: depth=%0d ovf=%b unf=%b want 0 0 0", depth, ovf, unf);
    end
  endtask

  initial begin
    rst = 1'b1; pc = '0; stall = 0; jmp = 0; br_taken = 0; jsr = 0; ret = 0; target = '0;
    test_reset();
    test_increment();
    test_call_return();
    test_nested();
    test_ret_empty();
    test_reset_mid();
    test_priority();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d left want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
